led_display_row_driver: RTL

Consumes rows from the pattern generator over a valid/ready handshake and drives a HUB75-style LED panel. Each captured row (top and bottom half-rows) is shifted serially into the panel, latched, and displayed for a fixed on-time before the next row is requested. It sits between the pattern generator and the panel pins and is the sink end of the `rgb_row_t` row interface.

---
 rtl/led_display_row_driver_if.sv | 49 ++++
 rtl/led_display_row_driver.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/led_display_row_driver_if.sv
// Row payload types and the pattern-generator -> row-driver handshake interface.
//   led_display_pkg         : panel geometry and the rgb_row_t row payload
//   led_display_row_driver_if: row_in / row_address_in / row_valid_in (master drives),
//                              row_ready_out (slave drives)

package led_display_pkg;

  localparam int unsigned GL_NUM_COL_PIXELS = 32;

  // One half-panel row: one bit per column for each colour plane.
  typedef struct packed {
    logic [GL_NUM_COL_PIXELS-1:0] red;
    logic [GL_NUM_COL_PIXELS-1:0] green;
    logic [GL_NUM_COL_PIXELS-1:0] blue;
  } rgb_half_t;

  // A full panel row pair: top half and bottom half are shifted together.
  typedef struct packed {
    rgb_half_t top;
    rgb_half_t bot;
  } rgb_row_t;

endpackage

interface led_display_row_driver_if;
  import led_display_pkg::*;

  rgb_row_t   row_in;
  logic [3:0] row_address_in;
  logic       row_valid_in;
  logic       row_ready_out;

  // Pattern generator side.
  modport master (
    output row_in,
    output row_address_in,
    output row_valid_in,
    input  row_ready_out
  );

  // Row driver side.
  modport slave (
    input  row_in,
    input  row_address_in,
    input  row_valid_in,
    output row_ready_out
  );

endinterface

// File: rtl/led_display_row_driver.sv
// HUB75-style row driver. Accepts one row pair over the row interface, shifts it
// out MSB column first on the six colour pins, latches it, then enables the panel
// for a fixed on-time before asking for the next row.
// Ports:
//   clk_in, n_reset_in : system clock, synchronous active-low reset
//   row_bus            : row handshake (slave side)
//   hub_r0/g0/b0       : top-half serial colour
//   hub_r1/g1/b1       : bottom-half serial colour
//   hub_clk            : panel shift clock
//   hub_lat            : panel latch strobe, active high
//   hub_oe_n           : panel output enable, active low
//   hub_addr           : panel row select

module led_display_row_driver
  import led_display_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ = 100_000_000,
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned ON_TIME      = 256,
  parameter int unsigned SIMULATION   = 0
) (
  input  logic                      clk_in,
  input  logic                      n_reset_in,
  led_display_row_driver_if.slave   row_bus,
  output logic                      hub_r0,
  output logic                      hub_g0,
  output logic                      hub_b0,
  output logic                      hub_r1,
  output logic                      hub_g1,
  output logic                      hub_b1,
  output logic                      hub_clk,
  output logic                      hub_lat,
  output logic                      hub_oe_n,
  output logic [3:0]                hub_addr
);

  localparam int unsigned N         = GL_NUM_COL_PIXELS;
  localparam int unsigned ON_CYCLES = (SIMULATION != 0) ? 8 : ON_TIME;
  localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned COL_W     = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ON_W      = $clog2(ON_CYCLES + 1);
  localparam int unsigned PIX_W     = 6;

  // Reject parameter sets the timing cannot honour.
  if (CLK_DIV < 1 || ON_TIME < 1 || SYS_CLK_FREQ == 0) begin : g_param_check
    $error("led_display_row_driver: CLK_DIV, ON_TIME and SYS_CLK_FREQ must be nonzero");
  end

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    BLANK,
    LATCH,
    DISPLAY
  } state_t;

  state_t            state_q,    state_d;
  logic [DIV_W-1:0]  div_q,      div_d;
  logic [COL_W-1:0]  col_q,      col_d;
  logic [ON_W-1:0]   on_q,       on_d;
  rgb_row_t          row_q,      row_d;
  logic [3:0]        cap_addr_q, cap_addr_d;
  logic              ready_q,    ready_d;
  logic [PIX_W-1:0]  pix_q,      pix_d;
  logic              hclk_q,     hclk_d;
  logic              lat_q,      lat_d;
  logic              oe_n_q,     oe_n_d;
  logic [3:0]        addr_q,     addr_d;

  // Colour pin bundle for one column, ordered {r0,g0,b0,r1,g1,b1}.
  function automatic logic [PIX_W-1:0] pixel_at(rgb_row_t r, logic [COL_W-1:0] c);
    return {r.top.red[c], r.top.green[c], r.top.blue[c],
            r.bot.red[c], r.bot.green[c], r.bot.blue[c]};
  endfunction

  // State and output registers.
  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      state_q    <= IDLE;
      div_q      <= '0;
      col_q      <= '0;
      on_q       <= '0;
      row_q      <= '0;
      cap_addr_q <= '0;
      ready_q    <= 1'b0;
      pix_q      <= '0;
      hclk_q     <= 1'b0;
      lat_q      <= 1'b0;
      oe_n_q     <= 1'b1;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      col_q      <= col_d;
      on_q       <= on_d;
      row_q      <= row_d;
      cap_addr_q <= cap_addr_d;
      ready_q    <= ready_d;
      pix_q      <= pix_d;
      hclk_q     <= hclk_d;
      lat_q      <= lat_d;
      oe_n_q     <= oe_n_d;
      addr_q     <= addr_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so
  // the registered pins line up with the state they belong to.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    col_d      = col_q;
    on_d       = on_q;
    row_d      = row_q;
    cap_addr_d = cap_addr_q;
    ready_d    = ready_q;
    pix_d      = pix_q;
    hclk_d     = hclk_q;
    lat_d      = lat_q;
    oe_n_d     = oe_n_q;
    addr_d     = addr_q;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (row_bus.row_valid_in && ready_q) begin
          row_d      = row_bus.row_in;
          cap_addr_d = row_bus.row_address_in;
          state_d    = SHIFT;
          col_d      = COL_W'(N - 1);
          div_d      = '0;
          hclk_d     = 1'b0;
          ready_d    = 1'b0;
          // Captured register is not loaded yet, so the first pixel comes from the bus.
          pix_d      = pixel_at(row_bus.row_in, COL_W'(N - 1));
        end
      end

      SHIFT: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!hclk_q) begin
            hclk_d = 1'b1;
          end else begin
            // Falling edge: either advance to the next column or finish the row.
            hclk_d = 1'b0;
            if (col_q == '0) begin
              state_d = BLANK;
              addr_d  = cap_addr_q;
            end else begin
              col_d = col_q - COL_W'(1);
              pix_d = pixel_at(row_q, col_q - COL_W'(1));
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      BLANK: begin
        state_d = LATCH;
        lat_d   = 1'b1;
      end

      LATCH: begin
        state_d = DISPLAY;
        lat_d   = 1'b0;
        oe_n_d  = 1'b0;
        on_d    = '0;
      end

      DISPLAY: begin
        if (on_q == ON_W'(ON_CYCLES - 1)) begin
          state_d = IDLE;
          oe_n_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          on_d = on_q + ON_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        hclk_d  = 1'b0;
        lat_d   = 1'b0;
        oe_n_d  = 1'b1;
        ready_d = 1'b0;
      end
    endcase
  end

  assign row_bus.row_ready_out = ready_q;
  assign {hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1} = pix_q;
  assign hub_clk  = hclk_q;
  assign hub_lat  = lat_q;
  assign hub_oe_n = oe_n_q;
  assign hub_addr = addr_q;

endmodule
